// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - ID-stage issue scoreboard with per-register latency countdowns
// Optional stall statistics ports are enabled by defining ID_SCOREBOARD_STATS_EN.
module id_scoreboard #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned ALU_LAT  = 0,
  parameter int unsigned NREG     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        hold,
  output logic        id_stall,
  output logic        id_issue,
  output logic [31:0] busy_mask
`ifdef ID_SCOREBOARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [7:0]  max_stall_run
`endif
);

  localparam logic [2:0] LOAD_SET = 3'(LOAD_LAT);
  localparam logic [2:0] ALU_SET  = 3'(ALU_LAT);

  logic [2:0] cnt_q [NREG];
  logic [2:0] cnt_d [NREG];
  logic [2:0] cnt_rs1;
  logic [2:0] cnt_rs2;
  logic       haz1;
  logic       haz2;

  // Lookup never reaches beyond NREG-1; entry 0 is held at zero.
  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    for (int r = 0; r < NREG; r++) begin
      if (id_rs1 == 5'(r)) cnt_rs1 = cnt_q[r];
      if (id_rs2 == 5'(r)) cnt_rs2 = cnt_q[r];
    end
  end

  assign haz1     = id_rs1_used & (id_rs1 != 5'd0) & (cnt_rs1 != 3'd0);
  assign haz2     = id_rs2_used & (id_rs2 != 5'd0) & (cnt_rs2 != 3'd0);
  assign id_stall = id_valid & ~hold & (haz1 | haz2);
  assign id_issue = id_valid & ~hold & ~haz1 & ~haz2;

  // A newly issued writer overrides the decrement of its own counter.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!hold) begin
        if (cnt_q[r] != 3'd0) cnt_d[r] = cnt_q[r] - 3'd1;
        if (id_issue && id_regwrite && (id_rd == 5'(r)))
          cnt_d[r] = id_memread ? LOAD_SET : ALU_SET;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset) cnt_q[r] <= '0;
      else       cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_mask[r] = (cnt_q[r] != 3'd0);
    end
  end

`ifdef ID_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [7:0]  run_q;
  logic [7:0]  run_d;
  logic [7:0]  max_q;

  always_comb begin
    run_d = 8'd0;
    if (id_stall) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      run_q          <= '0;
      max_q          <= '0;
    end else begin
      if (id_stall && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      run_q <= run_d;
      if (run_d > max_q) max_q <= run_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign max_stall_run = max_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed self-checking bench for id_scoreboard
// Two instances share stimulus: default latencies (d_*) and LOAD_LAT = 3 (l_*).
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, u1, u2, rw, mr, hold;
  logic [4:0]  rs1, rs2, rd;
  logic        d_stall, d_issue, l_stall, l_issue;
  logic [31:0] d_busy, l_busy;
`ifdef ID_SCOREBOARD_STATS_EN
  logic [31:0] d_sc, l_sc;
  logic [7:0]  d_mx, l_mx;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_scoreboard u_d (
    .clk(clk), .reset(reset), .id_valid(valid), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2), .id_rd(rd), .id_regwrite(rw),
    .id_memread(mr), .hold(hold), .id_stall(d_stall), .id_issue(d_issue),
    .busy_mask(d_busy)
`ifdef ID_SCOREBOARD_STATS_EN
    , .stall_cycles(d_sc), .max_stall_run(d_mx)
`endif
  );

  id_scoreboard #(.LOAD_LAT(3)) u_l (
    .clk(clk), .reset(reset), .id_valid(valid), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(u1), .id_rs2_used(u2), .id_rd(rd), .id_regwrite(rw),
    .id_memread(mr), .hold(hold), .id_stall(l_stall), .id_issue(l_issue),
    .busy_mask(l_busy)
`ifdef ID_SCOREBOARD_STATS_EN
    , .stall_cycles(l_sc), .max_stall_run(l_mx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic e1,
                       input logic [4:0] a2, input logic e2, input logic [4:0] d,
                       input logic w, input logic m, input logic h);
    valid = v; rs1 = a1; u1 = e1; rs2 = a2; u2 = e2;
    rd = d; rw = w; mr = m; hold = h;
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("reset_stall", {31'd0, d_stall}, 32'd0);
    chk("reset_issue", {31'd0, d_issue}, 32'd0);
    chk("reset_busy", d_busy, 32'd0);
    chk("reset_busy_l", l_busy, 32'd0);

    // load-use, LOAD_LAT = 1
    drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    chk("lu_ld_issue", {31'd0, d_issue}, 32'd1);
    tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("lu_stall", {31'd0, d_stall}, 32'd1);
    chk("lu_no_issue", {31'd0, d_issue}, 32'd0);
    chk("lu_busy5", d_busy, 32'h0000_0020);
    tick();
    chk("lu_issue", {31'd0, d_issue}, 32'd1);
    chk("lu_busy_clear", d_busy, 32'd0);
    tick();
    chk("lu_alu_not_busy", d_busy, 32'd0);
    idle(4);

    // no hazard
    drive(1, 2, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 2, 1, 3, 1, 7, 1, 0, 0);
    chk("nh_issue", {31'd0, d_issue}, 32'd1);
    chk("nh_stall", {31'd0, d_stall}, 32'd0);
    tick();
    drive(1, 5, 1, 0, 1, 8, 1, 0, 0);
    chk("nh_late_use", {31'd0, d_issue}, 32'd1);
    chk("nh_busy", d_busy, 32'd0);
    tick();
    idle(4);

    // x0 destination and unused source
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0);
    tick();
    chk("x0_busy", d_busy, 32'd0);
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0);
    chk("x0_stall", {31'd0, d_stall}, 32'd0);
    chk("x0_issue", {31'd0, d_issue}, 32'd1);
    tick();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 1, 1, 5, 0, 10, 1, 0, 0);
    chk("unused_busy", d_busy, 32'h0000_0020);
    chk("unused_stall", {31'd0, d_stall}, 32'd0);
    chk("unused_issue", {31'd0, d_issue}, 32'd1);
    tick();
    idle(4);

    // hold freezes counters, LOAD_LAT = 3
    drive(1, 1, 1, 0, 0, 9, 1, 1, 0);
    chk("hold_ld_issue", {31'd0, l_issue}, 32'd1);
    tick();
    drive(1, 9, 1, 0, 0, 10, 1, 0, 1);
    chk("hold_stall", {31'd0, l_stall}, 32'd0);
    chk("hold_issue", {31'd0, l_issue}, 32'd0);
    tick();
    tick();
    chk("hold_busy9", l_busy, 32'h0000_0200);
    drive(1, 9, 1, 0, 0, 10, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_run_stall%0d", i), {31'd0, l_stall}, 32'd1);
      tick();
    end
    chk("hold_run_issue", {31'd0, l_issue}, 32'd1);
    tick();
    idle(4);

    // WAW after hold: young ALU writer clears the load latency
    drive(1, 1, 1, 0, 0, 9, 1, 1, 0);
    tick();
    drive(1, 1, 1, 0, 0, 9, 1, 0, 1);
    chk("waw_hold_issue", {31'd0, l_issue}, 32'd0);
    tick();
    tick();
    drive(1, 1, 1, 0, 0, 9, 1, 0, 0);
    chk("waw_alu_issue", {31'd0, l_issue}, 32'd1);
    tick();
    drive(1, 9, 1, 0, 0, 11, 1, 0, 0);
    chk("waw_dep_issue", {31'd0, l_issue}, 32'd1);
    chk("waw_busy", l_busy, 32'd0);
    tick();
    idle(4);

    // reset while stalled
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
    chk("rst_pre_stall", {31'd0, l_stall}, 32'd1);
    tick();
    chk("rst_stall_cnt2", {31'd0, l_stall}, 32'd1);
    chk("rst_busy_pre", l_busy, 32'h0000_0020);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", l_busy, 32'd0);
    chk("rst_dep_issue", {31'd0, l_issue}, 32'd1);
    tick();

`ifdef ID_SCOREBOARD_STATS_EN
    chk("st_init_cycles", l_sc, 32'd0);
    chk("st_init_max", {24'd0, l_mx}, 32'd0);
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 7, 1, 0, 0);
    repeat (3) tick();
    chk("st_pair1_issue", {31'd0, l_issue}, 32'd1);
    tick();
    drive(1, 1, 1, 0, 0, 6, 1, 1, 0);
    tick();
    drive(1, 1, 0, 6, 1, 8, 1, 0, 0);
    repeat (3) tick();
    chk("st_pair2_issue", {31'd0, l_issue}, 32'd1);
    tick();
    chk("st_cycles", l_sc, 32'd6);
    chk("st_max", {24'd0, l_mx}, 32'd3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    #1;
    chk("st_rst_cycles", l_sc, 32'd0);
    chk("st_rst_max", {24'd0, l_mx}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Hazard/issue controller sequencing the instruction-decode stage (register file, immediate generator, main control).
- Tracks in-flight destination registers with per-register latency countdowns.
- Stalls ID while a source operand is not yet forwardable; grants issue otherwise.
- Sits between ID and ID/EX; the pipeline register loads only on `id_issue`.

Parameters:
- LOAD_LAT, 1, cycles after issue that a load result stays non-forwardable (1..7)
- ALU_LAT, 0, same for non-load register writers (0..7)
- NREG, 32, architectural registers; x0 hardwired zero

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a valid decoded instruction
- id_rs1  in  5  source register 1 (instruction[19:15])
- id_rs2  in  5  source register 2 (instruction[24:20])
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  5  destination (instruction[11:7])
- id_regwrite  in  1  instruction writes rd
- id_memread  in  1  instruction is a load
- hold  in  1  global freeze from a memory stall
- id_stall  out  1  ID must hold its instruction this cycle
- id_issue  out  1  instruction leaves ID this cycle
- busy_mask  out  32  bit r = 1 while cnt[r] != 0

Behaviour:
- State: cnt[1..NREG-1], 3-bit down-counters. cnt[0] is constant 0. No other control state.
- Reset: all cnt = 0, busy_mask = 0, id_stall = 0, id_issue = 0 in the cycle after reset. Reset mid-operation discards all in-flight tracking.
- Hazard (combinational, from registered cnt only):
  - haz1 = id_rs1_used & (id_rs1 != 0) & (cnt[id_rs1] != 0)
  - haz2 is the same for rs2.
- id_stall = id_valid & ~hold & (haz1 | haz2).
- id_issue = id_valid & ~hold & ~haz1 & ~haz2.
- id_valid = 0: both id_stall and id_issue are 0.
- Per clock edge, with hold = 1: all cnt frozen, no decrement, no issue.
- Per clock edge, with hold = 0:
  - Every nonzero cnt decrements by 1.
  - Then, if id_issue & id_regwrite & (id_rd != 0): cnt[id_rd] <= (id_memread ? LOAD_LAT : ALU_LAT).
  - This set overrides that register's decrement in the same cycle (WAW: youngest writer wins).
- Self-dependence (rs == rd of the same instruction): the check uses the pre-issue cnt.
- The counter never underflows: it is 0 and stays 0.
- With ALU_LAT = 0, ALU writers never set busy (full forwarding assumed).
- Latency: a stall decision is visible in the same cycle as the decoded inputs. A freed register is usable in the cycle its cnt reaches 0.
- busy_mask is registered-state derived (no combinational path from inputs). busy_mask[0] = 0.

Optional Feature:
- Macro: ID_SCOREBOARD_STATS_EN.
- When defined, adds two ports:
  - stall_cycles out 32: count of cycles with id_stall = 1; saturates at all-ones.
  - max_stall_run out 8: longest consecutive id_stall run seen; saturates at 255.
  - Both clear on reset.
  - A run ends on any cycle with id_stall = 0.
  - max_stall_run updates on the cycle the run's length exceeds the stored value.
- When undefined: ports and logic are absent; the core behaviour is identical.

Test Plan:
- Load-use, default params:
  - Cycle0: ld x5 issues.
  - Cycle1: add x6, x5, x1 -> id_stall = 1, id_issue = 0, busy_mask[5] = 1.
  - Cycle2: id_issue = 1, busy_mask[5] = 0.
- No hazard:
  - Cycle0: ld x5.
  - Cycle1: add x7, x2, x3 -> id_issue = 1, no stall.
  - Cycle2: add x8, x5, x0 -> issues (cnt[5] already 0).
- x0 and unused sources:
  - ld x0 followed by a use of x0 -> no stall, busy_mask = 0.
  - ld x5 followed by an instruction with id_rs2 = 5 but id_rs2_used = 0 -> no stall.
- Hold and WAW, LOAD_LAT = 3:
  - ld x9 issues, then hold = 1 for 2 cycles -> cnt[9] stays 3.
  - Release; in the next cycle an ALU write to x9 issues -> cnt[9] = 0 after the edge, so a dependent instruction issues immediately.
- Reset mid-stall:
  - Assert reset while a dependent instruction is stalled on x5 (cnt = 2, LOAD_LAT = 3) -> next cycle busy_mask = 0 and the dependent instruction issues.
- Stats (ID_SCOREBOARD_STATS_EN, LOAD_LAT = 3):
  - Two load-use pairs produce stall runs of 3 and 3 -> stall_cycles = 6, max_stall_run = 3.
  - Reset -> both read 0.
